// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks outstanding long-latency writes, stalls dependent issue,
// and merges ALU/LSU writebacks onto one registered register-file write port.
module reg_scoreboard #(
  parameter int MAX_PENDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic [4:0]  issue_rd,
  input  logic        issue_rd_we,
  input  logic        issue_long,
  input  logic        wb_alu_valid,
  input  logic [4:0]  wb_alu_addr,
  input  logic [31:0] wb_alu_data,
  input  logic        wb_lsu_valid,
  output logic        wb_lsu_ready,
  input  logic [4:0]  wb_lsu_addr,
  input  logic [31:0] wb_lsu_data,
  output logic        rf_write_enable,
  output logic [4:0]  rf_write_addr,
  output logic [31:0] rf_write_data,
  output logic [3:0]  busy_count,
  output logic        wb_error
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_PENDING);

  logic [31:0] busy;
  logic [31:0] busy_next;
  logic [3:0]  count;
  logic [3:0]  count_next;
  logic        error_flag;
  logic        at_max;
  logic        lsu_accept;
  logic        fire;
  logic        set_busy;
  logic        clr_busy;
  logic        error_event;

  // Readiness looks only at registered busy bits, so a result accepted this cycle
  // cannot release a dependent instruction until the following cycle (no bypass).
  always_comb begin
    at_max       = (count == MAX_CNT);
    lsu_accept   = wb_lsu_valid & ~wb_alu_valid;
    wb_lsu_ready = ~wb_alu_valid;
    issue_ready  = reset | ~(busy[issue_rs1] | busy[issue_rs2] |
                             (issue_rd_we & busy[issue_rd]) | (issue_long & at_max));
    fire         = issue_valid & issue_ready;
    set_busy     = fire & issue_rd_we & issue_long & (issue_rd != 5'd0);
    clr_busy     = lsu_accept & busy[wb_lsu_addr];
  end

  always_comb begin
    busy_next = busy;
    if (lsu_accept) busy_next[wb_lsu_addr] = 1'b0;
    if (set_busy)   busy_next[issue_rd]    = 1'b1;
    busy_next[0] = 1'b0;

    count_next = count;
    if (set_busy && !clr_busy && !at_max)
      count_next = count + 4'd1;
    else if (clr_busy && !set_busy && count != 4'd0)
      count_next = count - 4'd1;

    error_event = (lsu_accept && wb_lsu_addr != 5'd0 && !busy[wb_lsu_addr]) ||
                  (wb_alu_valid && busy[wb_alu_addr]) ||
                  (set_busy && !clr_busy && at_max);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 32'd0;
      count      <= 4'd0;
      error_flag <= 1'b0;
    end else begin
      busy       <= busy_next;
      count      <= count_next;
      error_flag <= error_flag | error_event;
    end
  end

  // ALU has fixed priority; writebacks to x0 are accepted but never enable the port.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_enable <= 1'b0;
      rf_write_addr   <= 5'd0;
      rf_write_data   <= 32'd0;
    end else if (wb_alu_valid) begin
      rf_write_enable <= (wb_alu_addr != 5'd0);
      rf_write_addr   <= wb_alu_addr;
      rf_write_data   <= wb_alu_data;
    end else if (lsu_accept) begin
      rf_write_enable <= (wb_lsu_addr != 5'd0);
      rf_write_addr   <= wb_lsu_addr;
      rf_write_data   <= wb_lsu_data;
    end else begin
      rf_write_enable <= 1'b0;
    end
  end

  assign busy_count = count;
  assign wb_error   = error_flag;

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL have parameter MAX_PENDING, default 4, giving the maximum outstanding long-latency writes (range 1..15).
REQ-002 The block SHALL have a single clock and a synchronous, active-high reset, with the following ports.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode stage presents an instruction.
- issue_ready  out  1  scoreboard accepts the instruction; fire = issue_valid & issue_ready.
- issue_rs1, issue_rs2  in  5 each  source register addresses.
- issue_rd  in  5  destination address.
- issue_rd_we  in  1  instruction writes rd.
- issue_long  in  1  result returns via the LSU writeback port (multi-cycle).
- wb_alu_valid  in  1  single-cycle ALU result valid (always accepted).
- wb_alu_addr  in  5  ALU result address.
- wb_alu_data  in  32  ALU result data.
- wb_lsu_valid  in  1  long-latency result valid.
- wb_lsu_ready  out  1  LSU result accepted this cycle.
- wb_lsu_addr  in  5  LSU result address.
- wb_lsu_data  in  32  LSU result data.
- rf_write_enable  out  1  register-file write port enable.
- rf_write_addr  out  5  register-file write port address.
- rf_write_data  out  32  register-file write port data.
- busy_count  out  4  number of outstanding long writes.
- wb_error  out  1  sticky protocol-violation flag.

Function
REQ-003 The block SHALL hold a 32-bit busy vector; busy[0] SHALL read as 0 at all times.
REQ-004 On issue fire with issue_rd_we=1, issue_long=1 and issue_rd!=0, busy[issue_rd] SHALL be set at the clock edge.
REQ-005 issue_ready SHALL be combinational and SHALL be 0 if any of the following hold, else 1:
- busy[issue_rs1]=1.
- busy[issue_rs2]=1.
- issue_rd_we=1 and busy[issue_rd]=1 (WAW).
- issue_long=1 and busy_count==MAX_PENDING.
REQ-006 wb_lsu_ready SHALL equal !wb_alu_valid, giving the ALU fixed priority; an LSU result not accepted SHALL be held by the source.
REQ-007 On LSU accept (wb_lsu_valid & wb_lsu_ready), busy[wb_lsu_addr] SHALL clear at that clock edge.
REQ-008 The scoreboard SHALL NOT bypass: a read of register X issued in the same cycle X's LSU result is accepted SHALL stall exactly that one cycle.
REQ-009 rf_write_* SHALL be registered, with one-cycle latency, from the accepted writeback:
- rf_write_enable is asserted the cycle after an ALU-valid or LSU-accept whose address is nonzero.
- rf_write_addr and rf_write_data carry that writeback's address and data.
REQ-010 A writeback to x0 SHALL produce rf_write_enable=0, and for an LSU writeback SHALL still be accepted.
REQ-011 When no writeback is accepted in a cycle, rf_write_enable SHALL be 0 in the next cycle; rf_write_addr and rf_write_data SHALL hold their values.
REQ-012 busy_count SHALL change as follows:
- +1 on a long-write issue fire with nonzero rd.
- -1 on an LSU accept whose address is busy.
- unchanged when both occur in the same cycle.
- never wraps.
REQ-013 wb_error SHALL set, and stay set until reset, on any of the following:
- an LSU accept to a nonbusy nonzero address (busy_count unchanged).
- an ALU writeback to a busy address (the write is still performed).
- a busy_count increment attempted at MAX_PENDING.
REQ-014 Issue fire and LSU accept targeting different registers in the same cycle SHALL both take effect.

Reset
REQ-015 While reset=1 at a clock edge, the block SHALL clear all of the following:
- the busy vector.
- busy_count to 0.
- wb_error to 0.
- rf_write_enable to 0.
- rf_write_addr to 0.
- rf_write_data to 0.
REQ-016 Reset asserted mid-operation SHALL discard all pending state; LSU results arriving after reset SHALL be treated per REQ-013.
REQ-017 While reset=1, issue_ready SHALL still be evaluated combinationally from the post-reset state (all ready unless MAX_PENDING reached is false).

Verification
REQ-018 Long load to x5 issued, then an instruction with rs1=5 is presented:
- issue_ready=0 until the LSU writeback of x5, data 0xDEADBEEF, is accepted.
- issue_ready=1 the next cycle.
- rf_write_enable=1, addr=5, data=0xDEADBEEF one cycle after the accept.
REQ-019 wb_alu_valid and wb_lsu_valid asserted together, addr 3 and 7:
- wb_lsu_ready=0 that cycle.
- ALU write to x3 occurs first, then the LSU write to x7 one cycle later.
REQ-020 Four long issues to x1..x4 with MAX_PENDING=4:
- busy_count=4.
- a fifth long issue sees issue_ready=0.
- a short ALU issue with independent registers sees issue_ready=1.
REQ-021 Long issue to x0 followed by an ALU writeback to x0:
- busy_count stays 0.
- rf_write_enable stays 0.
- wb_error stays 0.
REQ-022 LSU writeback to a nonbusy x9 sets wb_error=1; a following reset clears wb_error, busy_count and the busy vector to 0.
REQ-023 Same-cycle issue fire (long, rd=10) and LSU accept of x6:
- busy_count unchanged.
- busy[10]=1 and busy[6]=0 after the edge.
